// File: rtl/reg_bus_pkg.sv
// Shared types and default widths for the register-bus initiator slice.
package reg_bus_pkg;

  localparam int unsigned REG_AW = 11;
  localparam int unsigned REG_DW = 8;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_RD,
    RESP
  } state_t;

  typedef struct packed {
    logic              write;
    logic [REG_AW-1:0] addr;
    logic [REG_DW-1:0] wdata;
  } reg_cmd_t;

endpackage

// File: rtl/reg_bus_if.sv
// Register bus: initiator drives address/wdata/xfc/we, slave returns rdata.
interface reg_bus_if
  import reg_bus_pkg::*;
#(
  parameter int unsigned AW = REG_AW,
  parameter int unsigned DW = REG_DW
) ();

  logic [AW-1:0] address;
  logic [DW-1:0] wdata;
  logic          xfc;
  logic          we;
  logic [DW-1:0] rdata;

  modport master (output address, output wdata, output xfc, output we, input rdata);
  modport slave  (input address, input wdata, input xfc, input we, output rdata);

endinterface

// File: rtl/reg_cmd_fifo.sv
// Single-clock command FIFO; pointers carry an extra wrap bit for full/empty.
module reg_cmd_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 20
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned IW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [IW:0]      wr_ptr;
  logic [IW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[IW] != rd_ptr[IW]) && (wr_ptr[IW-1:0] == rd_ptr[IW-1:0]);
  assign level    = wr_ptr - rd_ptr;
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr[IW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[IW-1:0]] <= push_data;
  end

endmodule

// File: rtl/reg_bus_initiator.sv
// Register-bus initiator: queues host commands, issues single-cycle xfc strobes,
// returns read data. Optional minimum strobe spacing via REG_INIT_GAP_EN.
module reg_bus_initiator
  import reg_bus_pkg::*;
#(
  parameter int unsigned AW     = REG_AW,
  parameter int unsigned DW     = REG_DW,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned RD_LAT = 1,
  parameter int unsigned GAP    = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic                   cmd_write,
  input  logic [AW-1:0]          cmd_addr,
  input  logic [DW-1:0]          cmd_wdata,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [DW-1:0]          rsp_rdata,
  reg_bus_if.master              bus,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] fifo_level
);

  typedef struct packed {
    logic          write;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } cmd_t;

  localparam logic [2:0] LAT_LOAD = 3'(RD_LAT - 1);

  state_t        state, state_nxt;
  logic          pop;
  logic          full, empty;
  logic          gap_ok;
  logic [2:0]    lat_cnt;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic          we_q;
  logic [DW-1:0] rdata_q;
  cmd_t          head;
  logic [$bits(cmd_t)-1:0] head_raw;

  reg_cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(cmd_t))
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (cmd_valid),
    .push_data ({cmd_write, cmd_addr, cmd_wdata}),
    .pop       (pop),
    .pop_data  (head_raw),
    .full      (full),
    .empty     (empty),
    .level     (fifo_level)
  );

  assign head = cmd_t'(head_raw);

`ifdef REG_INIT_GAP_EN
  // Loading GAP-1 lets the pop decision land in the last idle cycle, so
  // strobes end up exactly GAP idle cycles apart (never fewer than one).
  localparam int unsigned GW = $clog2(GAP + 2);
  localparam logic [GW-1:0] GAP_LOAD = GW'((GAP > 0) ? GAP - 1 : 0);
  logic [GW-1:0] gap_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                gap_cnt <= '0;
    else if (state == ISSUE)   gap_cnt <= GAP_LOAD;
    else if (gap_cnt != '0)    gap_cnt <= gap_cnt - 1'b1;
  end

  assign gap_ok = (gap_cnt == '0);
`else
  assign gap_ok = 1'b1;
`endif

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        if (!empty && gap_ok) begin
          pop       = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE:   state_nxt = we_q ? IDLE : WAIT_RD;
      WAIT_RD: if (lat_cnt == '0) state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      lat_cnt <= '0;
      rdata_q <= '0;
    end else begin
      state <= state_nxt;
      if (pop) begin
        addr_q  <= head.addr;
        wdata_q <= head.write ? head.wdata : '0;
        we_q    <= head.write;
      end
      if (state == ISSUE)
        lat_cnt <= LAT_LOAD;
      else if (state == WAIT_RD && lat_cnt != '0)
        lat_cnt <= lat_cnt - 1'b1;
      if (state == WAIT_RD && lat_cnt == '0)
        rdata_q <= bus.rdata;
    end
  end

  assign bus.xfc     = (state == ISSUE);
  assign bus.address = addr_q;
  assign bus.wdata   = wdata_q;
  assign bus.we      = we_q;
  assign cmd_ready   = !full;
  assign rsp_valid   = (state == RESP);
  assign rsp_rdata   = rdata_q;
  assign busy        = (fifo_level != '0) || (state != IDLE);

endmodule
